mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified instruction/data memory in the RISC-V pipeline. It shares one memory port between the instruction-fetch stage and the MEM stage. It issues one transaction at a time, waits out the fixed memory latency and routes the response back to the winner. Data accesses have priority, and a starvation counter forces periodic fetch grants.

## Interface
Parameters:
- ADDR_W, 8, requester byte-address width; the memory word index is addr[ADDR_W-1:2].
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from command to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 3, consecutive data grants tolerated while fetch waits; legal range 1..7.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; if_addr must be held stable until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch command accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: fetch data available.
- if_rdata  out  DATA_W  registered fetch data; held until the next fetch response.
- d_req  in  1  data request; d_we, d_addr and d_wdata must be held stable until d_gnt.
- d_we  in  1  1 means write, 0 means read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data command accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: read data available, or write acknowledged.
- d_rdata  out  DATA_W  registered read data; unchanged by writes.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  memory word index.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the command.
- busy  out  1  high while a transaction is outstanding (state WAIT).

## Operation
FSM states are IDLE and WAIT.

- **IDLE, no request:** all grants and mem_* outputs are 0.
- **IDLE, request present:** the winner is selected combinationally. In the same cycle the block asserts the winner's gnt, mem_en=1, mem_addr=addr[ADDR_W-1:2], mem_we=d_we (0 for fetch) and mem_wdata=d_wdata (0 for fetch). It then registers the owner and goes to WAIT.
- **WAIT:** a down-counter is loaded with MEM_LAT-1 and counts to 0. Grants and mem_en stay low, and requests are ignored.
- **WAIT, counter at 0:** the owner's read data is captured from mem_rdata (reads only), the owner's rvalid pulses in the next cycle, and the FSM returns to IDLE.
- **Arbitration order:**
  - Only one requester: it wins.
  - Both requesting: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- **starve_cnt (3 bits):**
  - Increments, saturating, on each data grant while if_req=1.
  - Clears on a fetch grant.
  - Clears in any IDLE cycle with if_req=0.
- **Requester behaviour:** a requester may keep req high after gnt to queue its next access. The new address is sampled at the next grant.
- **Outstanding transactions:** never more than one. Write and read use the same occupancy.

## Timing
- Command issued in cycle T (gnt=1):
  - busy=1 in cycles T+1..T+MEM_LAT.
  - mem_rdata is sampled at the end of cycle T+MEM_LAT.
  - rvalid=1 in cycle T+MEM_LAT+1, together with the new rdata.
- The next grant can occur in cycle T+MEM_LAT+1, the same cycle as the rvalid pulse. Peak throughput is therefore one access per MEM_LAT+1 cycles.
- Grant latency from req in IDLE is 0 cycles (combinational).
- **Reset values:** state=IDLE, starve_cnt=0, if_rdata=0, d_rdata=0, owner=fetch, and every output 0.
- **Reset asserted during WAIT:** the transaction is abandoned with no rvalid. After release, the first arbitration uses a cleared counter.
- **Request dropped before gnt:** no side effect.
- **Request changed during WAIT:** no effect until the FSM returns to IDLE.

## Test plan
1. **Fetch only, MEM_LAT=1.** Stimulus: if_req=1, if_addr=0x04, memory returns 0x00500093. Required: if_gnt and mem_en in cycle 0, mem_addr=1, mem_we=0. if_rvalid in cycle 2 with if_rdata=0x00500093. Next if_gnt in cycle 2.
2. **Simultaneous reads.** Stimulus: if_req=1, d_req=1 in cycle 0, d_addr=0x08. Required: d_gnt=1, if_gnt=0, mem_addr=2. d_rvalid in cycle 2. if_gnt in cycle 2.
3. **Starvation, STARVE_MAX=3, MEM_LAT=1.** Stimulus: both requests held high continuously. Required grant sequence (one grant per 2 cycles): D,D,D,F,D,D,D,F.
4. **Data write.** Stimulus: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF. Required: mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF in the grant cycle. d_rvalid 2 cycles later. d_rdata keeps its previous value.
5. **MEM_LAT=3.** Stimulus: back-to-back fetches to 0x00 and 0x04. Required: grants in cycles 0 and 4, busy high in cycles 1–3, if_rvalid in cycles 4 and 8. A d_req raised in cycle 2 is not granted before cycle 4.
6. **Reset mid-WAIT, MEM_LAT=3.** Stimulus: reset=0 in cycle 2 after a grant in cycle 0. Required: busy, rvalid and rdata all 0 immediately. After release with both requests high, d_gnt is first and starve_cnt starts from 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage:
// data-first arbitration with a starvation counter, one access in flight, fixed latency.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  localparam logic [2:0] SMAX   = 3'(STARVE_MAX);

  state_t     state, state_nxt;
  logic       owner;     // 1 = data port owns the in-flight access
  logic       owner_we;
  logic [1:0] cnt;
  logic [2:0] starve_cnt;
  logic       pick_f, pick_d;
  req_t       win;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

  assign busy = (state == S_WAIT);

  always_comb begin
    state_nxt = state;
    pick_f    = 1'b0;
    pick_d    = 1'b0;
    win       = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        pick_f = if_req && (!d_req || starve_cnt == SMAX);
        pick_d = d_req && !pick_f;
        if (pick_d) win = {d_we, d_addr, d_wdata};
        else        win = {1'b0, if_addr, {DATA_W{1'b0}}};
        if (pick_f || pick_d) begin
          if_gnt    = pick_f;
          d_gnt     = pick_d;
          mem_en    = 1'b1;
          mem_we    = win.we;
          mem_addr  = win.addr[ADDR_W-1:2];
          mem_wdata = win.wdata;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (cnt == 2'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      owner_we   <= 1'b0;
      cnt        <= '0;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (if_gnt || d_gnt) begin
        owner    <= d_gnt;
        owner_we <= d_gnt && d_we;
        cnt      <= LAT_M1;
      end
      if (state == S_WAIT) begin
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
        else if (owner) begin
          d_rvalid <= 1'b1;
          if (!owner_we) d_rdata <= mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
      // Counts data wins that bypassed a waiting fetch.
      if (if_gnt)
        starve_cnt <= '0;
      else if (d_gnt && if_req) begin
        if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
      end else if (state == S_IDLE && !if_req)
        starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: MEM_LAT=1 instance driven from a vector table, MEM_LAT=3 instance
// exercised by hand-written latency, late-request and reset-in-WAIT sequences.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [31:0] d_wdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [5:0]  a_mem_addr, a_last;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [5:0]  b_mem_addr, b_last;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy));

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(3)) u3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: contents fixed per word; data for the last command is held until the next one.
  function automatic logic [31:0] rom(input logic [5:0] w);
    return (w == 6'd1) ? 32'h00500093 : (32'hC0DE0000 | 32'(w));
  endfunction

  initial begin a_last = '0; b_last = '0; end
  always @(posedge clk) begin
    if (a_mem_en) a_last <= a_mem_addr;
    if (b_mem_en) b_last <= b_mem_addr;
  end
  assign a_mem_rdata = rom(a_last);
  assign b_mem_rdata = rom(b_last);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ctl = {if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid}
  typedef struct packed {
    logic        ir;
    logic [7:0]  ia;
    logic        dr;
    logic        dw;
    logic [7:0]  da;
    logic [31:0] dwd;
    logic [6:0]  ctl;
    logic [5:0]  ma;
    logic [31:0] mwd;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                     input logic [7:0] da, input logic [31:0] dwd, input logic [6:0] ctl,
                     input logic [5:0] ma, input logic [31:0] mwd,
                     input logic [31:0] ird, input logic [31:0] drd);
    vecs.push_back('{ir, ia, dr, dw, da, dwd, ctl, ma, mwd, ird, drd});
  endtask

  task automatic drive(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                       input logic [7:0] da, input logic [31:0] dwd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  logic [4:0] s5_exp [17];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 32'h0);
    @(negedge clk); #1;
    chk("reset u1 outputs", {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_if_rvalid, a_d_rvalid,
                             a_mem_addr, a_mem_wdata}, '0);
    chk("reset u1 rdata", {a_if_rdata, a_d_rdata}, '0);
    chk("reset u3 outputs", {b_if_gnt, b_d_gnt, b_mem_en, b_busy, b_if_rvalid, b_d_rvalid,
                             b_if_rdata[15:0], b_d_rdata[15:0]}, '0);
    @(negedge clk); reset = 1'b1;

    // fetch only, queued second fetch
    add(1, 8'h04, 0, 0, 8'h00, 0, 7'b1010000, 6'd1, 0, 32'h0, 32'h0);
    add(1, 8'h04, 0, 0, 8'h00, 0, 7'b0000100, 6'd0, 0, 32'h0, 32'h0);
    add(1, 8'h04, 0, 0, 8'h00, 0, 7'b1010010, 6'd1, 0, 32'h00500093, 32'h0);
    add(0, 8'h04, 0, 0, 8'h00, 0, 7'b0000100, 6'd0, 0, 32'h00500093, 32'h0);
    add(0, 8'h04, 0, 0, 8'h00, 0, 7'b0000010, 6'd0, 0, 32'h00500093, 32'h0);
    // simultaneous reads: data first, fetch next
    add(1, 8'h00, 1, 0, 8'h08, 0, 7'b0110000, 6'd2, 0, 32'h00500093, 32'h0);
    add(1, 8'h00, 0, 0, 8'h08, 0, 7'b0000100, 6'd0, 0, 32'h00500093, 32'h0);
    add(1, 8'h00, 0, 0, 8'h08, 0, 7'b1010001, 6'd0, 0, 32'h00500093, 32'hC0DE0002);
    add(0, 8'h00, 0, 0, 8'h08, 0, 7'b0000100, 6'd0, 0, 32'h00500093, 32'hC0DE0002);
    add(0, 8'h00, 0, 0, 8'h08, 0, 7'b0000010, 6'd0, 0, 32'hC0DE0000, 32'hC0DE0002);
    // starvation: D,D,D,F,D,D,D,F
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0110000, 6'd5, 0, 32'hC0DE0000, 32'hC0DE0002);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0000, 32'hC0DE0002);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0110001, 6'd5, 0, 32'hC0DE0000, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0000, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0110001, 6'd5, 0, 32'hC0DE0000, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0000, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b1010001, 6'd3, 0, 32'hC0DE0000, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0000, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0110010, 6'd5, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0110001, 6'd5, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0110001, 6'd5, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b1010001, 6'd3, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(1, 8'h0C, 1, 0, 8'h14, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(0, 8'h0C, 0, 0, 8'h14, 0, 7'b0000010, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    // data write: acked, d_rdata untouched
    add(0, 8'h00, 1, 1, 8'h10, 32'hDEADBEEF, 7'b0111000, 6'd4, 32'hDEADBEEF, 32'hC0DE0003, 32'hC0DE0005);
    add(0, 8'h00, 0, 0, 8'h10, 0, 7'b0000100, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(0, 8'h00, 0, 0, 8'h10, 0, 7'b0000001, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    // request raised and dropped during WAIT has no effect
    add(1, 8'h08, 0, 0, 8'h00, 0, 7'b1010000, 6'd2, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(0, 8'h08, 1, 1, 8'h18, 32'h12345678, 7'b0000100, 6'd0, 0, 32'hC0DE0003, 32'hC0DE0005);
    add(0, 8'h08, 0, 0, 8'h18, 0, 7'b0000010, 6'd0, 0, 32'hC0DE0002, 32'hC0DE0005);
    add(0, 8'h08, 0, 0, 8'h18, 0, 7'b0000000, 6'd0, 0, 32'hC0DE0002, 32'hC0DE0005);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd);
      #1;
      chk($sformatf("v%0d ctl", i),
          {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_if_rvalid, a_d_rvalid}, vecs[i].ctl);
      if (vecs[i].ctl[4])
        chk($sformatf("v%0d mem_addr/wdata", i), {a_mem_addr, a_mem_wdata}, {vecs[i].ma, vecs[i].mwd});
      chk($sformatf("v%0d rdata", i), {a_if_rdata, a_d_rdata}, {vecs[i].ird, vecs[i].drd});
    end

    // MEM_LAT=3: back-to-back fetches, then a data request raised mid-WAIT
    @(negedge clk); reset = 1'b0; drive(0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk); reset = 1'b1;
    // {if_gnt, d_gnt, busy, if_rvalid, d_rvalid}
    s5_exp = '{5'b10000, 5'b00100, 5'b00100, 5'b00100, 5'b10010, 5'b00100, 5'b00100, 5'b00100,
               5'b10010, 5'b00100, 5'b00100, 5'b00100, 5'b01010, 5'b00100, 5'b00100, 5'b00100,
               5'b00001};
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      case (c)
        0:  begin if_req = 1'b1; if_addr = 8'h00; end
        1:  if_addr = 8'h04;
        5:  if_addr = 8'h0C;
        9:  if_req = 1'b0;
        10: begin d_req = 1'b1; d_we = 1'b0; d_addr = 8'h08; end
        13: d_req = 1'b0;
        default: ;
      endcase
      #1;
      chk($sformatf("lat3 c%0d", c), {b_if_gnt, b_d_gnt, b_busy, b_if_rvalid, b_d_rvalid}, s5_exp[c]);
      case (c)
        0:  chk("lat3 c0 mem_addr", b_mem_addr, 6'd0);
        4:  chk("lat3 c4 addr/rdata", {b_mem_addr, b_if_rdata}, {6'd1, 32'hC0DE0000});
        8:  chk("lat3 c8 addr/rdata", {b_mem_addr, b_if_rdata}, {6'd3, 32'h00500093});
        12: chk("lat3 c12 addr/rdata", {b_mem_addr, b_if_rdata}, {6'd2, 32'hC0DE0003});
        16: chk("lat3 c16 d_rdata", b_d_rdata, 32'hC0DE0002);
        default: ;
      endcase
    end

    // Reset mid-WAIT after three starving data grants
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) drive(1, 8'h00, 1, 0, 8'h08, 0);
      if (c == 10) reset = 1'b0;
      #1;
      if (c % 4 == 0 && c < 10)
        chk($sformatf("rst-seq grant c%0d", c), {b_if_gnt, b_d_gnt}, 2'b01);
    end
    chk("reset in WAIT clears", {b_busy, b_if_rvalid, b_d_rvalid, b_if_rdata, b_d_rdata}, '0);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b1;
      #1;
      if (c % 4 == 0)
        chk($sformatf("post-reset grant c%0d", c), {b_if_gnt, b_d_gnt}, (c == 12) ? 2'b10 : 2'b01);
    end

    drive(0, 8'h00, 0, 0, 8'h00, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
